// File: rtl/mm_data_arb.sv
// Two-master, one-slave OBI arbiter for the mm_ram data port: round-robin issue with
// a locked address phase, and in-order response routing through an outstanding-ID FIFO.
module mm_data_arb #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,

  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,

  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,

  output logic                  err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    LockNone,
    LockM0,
    LockM1
  } lock_e;

  lock_e             lockState_q, lockState_d;
  logic              rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              idFifo_q [MAX_OUTSTANDING];

  logic              selValid;
  logic              selId;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              accept;
  logic              pop;
  logic              headId;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FULL_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lockState_q <= LockNone;
    end else begin
      lockState_q <= lockState_d;
    end
  end

  // A pending (requested but not granted) address phase pins the selection until accepted;
  // a locked master that drops req leaves s_req_o low, so the lock falls away next cycle.
  always_comb begin
    lockState_d = LockNone;
    if (s_req_o && !s_gnt_i) begin
      lockState_d = selId ? LockM1 : LockM0;
    end
  end

  always_comb begin
    selValid = 1'b0;
    selId    = rrPtr_q;
    if (!fifoFull) begin
      case (lockState_q)
        LockM0: begin
          selValid = 1'b1;
          selId    = 1'b0;
        end
        LockM1: begin
          selValid = 1'b1;
          selId    = 1'b1;
        end
        default: begin
          if (m0_req_i && m1_req_i) begin
            selValid = 1'b1;
            selId    = rrPtr_q;
          end else if (m0_req_i) begin
            selValid = 1'b1;
            selId    = 1'b0;
          end else if (m1_req_i) begin
            selValid = 1'b1;
            selId    = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (selValid) begin
      if (selId) begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_addr_o  = m0_addr_i;
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  assign s_req_o  = selValid && (selId ? m1_req_i : m0_req_i);
  assign accept   = s_req_o && s_gnt_i;
  assign m0_gnt_o = accept && !selId;
  assign m1_gnt_o = accept && selId;

  // Responses return with zero added latency: the FIFO head steers s_rdata_i straight through.
  assign pop    = s_rvalid_i && !fifoEmpty;
  assign headId = idFifo_q[rdPtr_q];

  assign m0_rvalid_o = pop && !headId;
  assign m1_rvalid_o = pop && headId;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
  assign err_o       = err_q;

  always_comb begin
    rrPtr_d = rrPtr_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    err_d   = err_q | (s_rvalid_i && fifoEmpty);
    if (accept) begin
      rrPtr_d = !selId;
      wrPtr_d = nextPtr(wrPtr_q);
    end
    if (pop) begin
      rdPtr_d = nextPtr(rdPtr_q);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rrPtr_q <= 1'b0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Slot contents are only read while the count marks them live, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idFifo_q[wrPtr_q] <= selId;
    end
  end

endmodule

// File: doc/mm_data_arb.md
Name: mm_data_arb

Overview:
- Two-master to one-slave arbiter for the mm_ram data port.
- Shares the data port between the core LSU (master 0) and a debug/loader/DMA master (master 1).
- Protocol on all sides is OBI-style: req/gnt address phase, then an rvalid response phase.
- Round-robin fair; routes responses back in order via an outstanding-ID FIFO.

Parameters:
ADDR_WIDTH, 32, address width of masters and slave
DATA_WIDTH, 32, read/write data width
MAX_OUTSTANDING, 2, depth of outstanding-transaction ID FIFO (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m0_req_i  in  1  master 0 request
m0_addr_i  in  ADDR_WIDTH  master 0 address
m0_we_i  in  1  master 0 write enable
m0_be_i  in  4  master 0 byte enables
m0_wdata_i  in  DATA_WIDTH  master 0 write data
m0_gnt_o  out  1  master 0 grant
m0_rvalid_o  out  1  master 0 response valid
m0_rdata_o  out  DATA_WIDTH  master 0 read data
m1_*  same set as m0_* for master 1
s_req_o  out  1  slave request
s_addr_o  out  ADDR_WIDTH  slave address
s_we_o  out  1  slave write enable
s_be_o  out  4  slave byte enables
s_wdata_o  out  DATA_WIDTH  slave write data
s_gnt_i  in  1  slave grant (may be combinational from s_req_o)
s_rvalid_i  in  1  slave response valid
s_rdata_i  in  DATA_WIDTH  slave read data
err_o  out  1  sticky: s_rvalid_i received with FIFO empty

Behaviour:
- Reset (async): round-robin pointer = m0; lock = none; FIFO empty; err_o=0.
  - All gnt/rvalid outputs are 0. rdata outputs are 0. s_req_o follows the arbitration, which is 0 with no requests.
- Arbitration is combinational.
  - If lock is valid, select the locked master.
  - Else if only one master requests, select it.
  - Else if both request, select the pointer master.
  - If the FIFO is full, nothing is selected.
- s_req_o = selected master's req.
- s_addr/we/be/wdata = selected master's fields; all 0 when none is selected.
- mK_gnt_o = s_gnt_i && s_req_o && (selected==K). The unselected master's gnt is 0.
- Accept = s_req_o && s_gnt_i.
  - Push the selected ID into the FIFO.
  - Set the pointer to the other master.
  - Clear the lock.
- s_req_o && !s_gnt_i: latch the selected master into lock. This keeps the slave address phase stable until granted, even if the other master then requests.
- Lock is only cleared by accept or reset.
  - A locked master dropping req is a protocol violation.
  - In that case the arbiter clears the lock next cycle.
- FIFO full blocks issue even when a pop happens in the same cycle (no bypass).
- s_rvalid_i with FIFO non-empty:
  - Pop the head ID.
  - mHEAD_rvalid_o = 1 and mHEAD_rdata_o = s_rdata_i, in the same cycle (0 added latency).
  - The other master's rvalid=0 and rdata=0.
- s_rvalid_i with FIFO empty: ignored; err_o set and held until reset.
- Simultaneous push and pop on a non-full FIFO: both occur; the count is unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING. The count is tracked separately to distinguish full from empty.
- Responses are strictly in acceptance order. Writes also produce an rvalid, which is routed the same way.
- Reset mid-transaction drops all outstanding IDs. A late s_rvalid_i after reset sets err_o.

Test Plan:
- m0 read 0x100 alone, slave gnt same cycle, rvalid next cycle with 0xDEADBEEF:
  - m0_gnt_o=1 in cycle 0.
  - m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF in cycle 1.
  - m1 outputs stay 0.
- Both masters request continuously, slave always grants: grants alternate m0,m1,m0,m1 (pointer starts at m0); each rvalid goes to the matching master.
- m1 requests 0x2000_0000 and the slave withholds gnt 3 cycles while m0 requests: s_addr_o stays 0x2000_0000 and m0_gnt_o=0 until m1 is granted; m0 is granted next.
- MAX_OUTSTANDING=2, slave grants but delays rvalid 4 cycles:
  - After 2 accepts, s_req_o=0.
  - s_req_o reasserts the cycle after the first pop, not in the pop cycle.
- Inject s_rvalid_i with no outstanding transaction: no mK_rvalid_o asserts; err_o=1 and stays 1 until rst_ni low.
- Assert rst_ni low with 2 outstanding: all outputs 0 asynchronously; after release, m0 wins the first simultaneous request.
